mastermind_score_seq: RTL

- Multi-cycle scoring sequencer for the Mastermind/Wordle game.
- Accepts a confirmed 4-peg guess from the core FSM's check step and compares it with the secret answer: one peg per cycle for exact matches, then one colour per cycle for colour-only matches.
- Tracks the guess count and win/lose status.
- Results feed the VGA renderer and the core FSM's DoneC/DoneNC decision.

---
 rtl/mastermind_score_seq.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/mastermind_score_seq.sv
// rtl/mastermind_score_seq.sv - Mastermind guess scoring sequencer (exact pass, then colour pass)
// Optional MASTERMIND_HISTORY_EN keeps a per-guess {guess, exact, partial} history.
module mastermind_score_seq #(
  parameter int NUM_PEGS    = 4,
  parameter int COLOR_W     = 3,
  parameter int NUM_COLORS  = 6,
  parameter int MAX_GUESSES = 8
) (
  input  logic                          Clk,
  input  logic                          Reset_n,
  input  logic                          new_game,
  input  logic                          start,
  input  logic [NUM_PEGS*COLOR_W-1:0]   guess,
  input  logic [NUM_PEGS*COLOR_W-1:0]   answer,
  output logic                          busy,
  output logic                          done,
  output logic                          invalid,
  output logic [2:0]                    exact,
  output logic [2:0]                    partial,
  output logic [2:0]                    guess_num,
  output logic                          win,
  output logic                          lose,
  input  logic [2:0]                    hist_addr,
  output logic [NUM_PEGS*COLOR_W+5:0]   hist_data
);

  localparam int IW  = (NUM_PEGS > 1) ? $clog2(NUM_PEGS) : 1;
  localparam int CLW = $clog2(NUM_COLORS + 1);
  localparam int GW  = $clog2(MAX_GUESSES + 1);
  localparam int HW  = (MAX_GUESSES > 1) ? $clog2(MAX_GUESSES) : 1;
  localparam int PW  = NUM_PEGS * COLOR_W;

  typedef enum logic [1:0] {S_IDLE, S_EXACT, S_COLOR, S_FINISH} state_t;

  state_t              r_state, w_next;
  logic [PW-1:0]       r_g, r_a;
  logic [NUM_PEGS-1:0] r_matched;
  logic [IW-1:0]       r_idx;
  logic [CLW-1:0]      r_col;
  logic [2:0]          r_exact_cnt, r_part_cnt;
  logic [2:0]          r_exact, r_partial;
  logic [GW-1:0]       r_guess_num;
  logic                r_pending, r_done, r_invalid, r_win, r_lose;

  logic                w_start_ok, w_valid;
  logic [COLOR_W-1:0]  w_g_cur, w_a_cur;
  logic [2:0]          w_gc, w_ac, w_min;

  // A start is latched first and validated on the following edge.
  assign w_start_ok = start && !new_game && (r_state == S_IDLE) && !r_pending && !r_win && !r_lose;

  always_comb begin
    w_valid = 1'b1;
    w_g_cur = '0;
    w_a_cur = '0;
    w_gc    = '0;
    w_ac    = '0;
    for (int i = 0; i < NUM_PEGS; i++) begin
      if ((r_g[i*COLOR_W +: COLOR_W] == '0) || (r_g[i*COLOR_W +: COLOR_W] > COLOR_W'(NUM_COLORS)))
        w_valid = 1'b0;
      if (IW'(i) == r_idx) begin
        w_g_cur = r_g[i*COLOR_W +: COLOR_W];
        w_a_cur = r_a[i*COLOR_W +: COLOR_W];
      end
      if (!r_matched[i] && (r_g[i*COLOR_W +: COLOR_W] == COLOR_W'(r_col))) w_gc = w_gc + 3'd1;
      if (!r_matched[i] && (r_a[i*COLOR_W +: COLOR_W] == COLOR_W'(r_col))) w_ac = w_ac + 3'd1;
    end
    w_min = (w_gc < w_ac) ? w_gc : w_ac;
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (r_pending && w_valid) w_next = S_EXACT;
      S_EXACT:  if (r_idx == IW'(NUM_PEGS - 1)) w_next = S_COLOR;
      S_COLOR:  if (r_col == CLW'(NUM_COLORS)) w_next = S_FINISH;
      S_FINISH: w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
    if (new_game) w_next = S_IDLE;
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      r_g <= '0; r_a <= '0; r_matched <= '0; r_idx <= '0; r_col <= '0;
      r_exact_cnt <= '0; r_part_cnt <= '0; r_exact <= '0; r_partial <= '0;
      r_guess_num <= '0; r_pending <= 1'b0; r_done <= 1'b0; r_invalid <= 1'b0;
      r_win <= 1'b0; r_lose <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (new_game) begin
        r_pending   <= 1'b0;
        r_guess_num <= '0;
        r_win       <= 1'b0;
        r_lose      <= 1'b0;
        r_invalid   <= 1'b0;
      end else begin
        if (w_start_ok) begin
          r_g         <= guess;
          r_a         <= answer;
          r_matched   <= '0;
          r_exact_cnt <= '0;
          r_part_cnt  <= '0;
          r_idx       <= '0;
          r_col       <= CLW'(1);
          r_pending   <= 1'b1;
          r_invalid   <= 1'b0;
        end
        case (r_state)
          S_IDLE: begin
            if (r_pending) begin
              r_pending <= 1'b0;
              if (!w_valid) begin
                r_done    <= 1'b1;
                r_invalid <= 1'b1;
              end
            end
          end
          S_EXACT: begin
            if (w_g_cur == w_a_cur) begin
              r_exact_cnt      <= r_exact_cnt + 3'd1;
              r_matched[r_idx] <= 1'b1;
            end
            r_idx <= r_idx + IW'(1);
          end
          S_COLOR: begin
            r_part_cnt <= r_part_cnt + w_min;
            r_col      <= r_col + CLW'(1);
          end
          S_FINISH: begin
            r_done      <= 1'b1;
            r_exact     <= r_exact_cnt;
            r_partial   <= r_part_cnt;
            r_guess_num <= r_guess_num + GW'(1);
            if (r_exact_cnt == 3'(NUM_PEGS))                          r_win  <= 1'b1;
            else if ((r_guess_num + GW'(1)) == GW'(MAX_GUESSES))      r_lose <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

`ifdef MASTERMIND_HISTORY_EN
  logic [PW+5:0] r_hist [MAX_GUESSES];

  always_ff @(posedge Clk) begin
    if (!Reset_n || new_game) begin
      for (int i = 0; i < MAX_GUESSES; i++) r_hist[i] <= '0;
    end else if (r_state == S_FINISH) begin
      r_hist[HW'(r_guess_num)] <= {r_g, r_exact_cnt, r_part_cnt};
    end
  end

  assign hist_data = r_hist[HW'(hist_addr)];
`else
  logic w_unused_hist_addr;
  assign w_unused_hist_addr = ^hist_addr;
  assign hist_data          = '0;
`endif

  assign busy      = (r_state != S_IDLE);
  assign done      = r_done;
  assign invalid   = r_invalid;
  assign exact     = r_exact;
  assign partial   = r_partial;
  assign guess_num = 3'(r_guess_num);
  assign win       = r_win;
  assign lose      = r_lose;

endmodule
